pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 148 ++++++++++++++
 tb/tb_pc_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen -- program counter generator for the instruction fetch front end.
//
// Presents one fetch request at a time (fetch_valid/fetch_pc) and advances
// by one instruction on every fetch handshake. Traps and branch redirects
// replace the PC with a latency of one cycle; halt_req parks the generator
// after the outstanding request is accepted.
//
// Parameters
//   XLEN          PC / address width (32 or 64)
//   RESET_VECTOR  first fetch address after reset
//   ALIGN_BITS    number of PC LSBs that must be zero
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   fetch_ready                 fetch port accepts the current request
//   fetch_valid, fetch_pc       current fetch request
//   redirect_valid, redirect_pc branch/jump redirect (one-cycle pulse)
//   trap_valid, trap_pc         exception/interrupt redirect (one-cycle pulse)
//   halt_req                    level request to stop sequential fetch
//   halted                      generator is parked in HALT
//   misalign_err                one-cycle pulse on a misaligned target
//
// Build option
//   PC_GEN_MISALIGN_TRAP_EN  defined: misaligned targets are dropped and
//                            flagged on misalign_err. Undefined: target LSBs
//                            are cleared and misalign_err is tied to 0.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_ready,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            halt_req,
  output logic            halted,
  output logic            misalign_err
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  localparam logic [XLEN-1:0] INC  = {{(XLEN-1){1'b0}}, 1'b1} << ALIGN_BITS;
  localparam logic [XLEN-1:0] MASK = INC - 1'b1;

  state_t          r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_halted;

  logic            w_hs;
  logic            w_active;
  logic            w_trap_bad;
  logic            w_redir_bad;
  logic [XLEN-1:0] w_trap_tgt;
  logic [XLEN-1:0] w_redir_tgt;
  logic            w_take_trap;
  logic            w_take_redir;

  assign w_hs     = r_valid & fetch_ready;
  // Traps are honoured in RUN and HALT; redirects only in RUN.
  assign w_active = (r_state == S_RUN) || (r_state == S_HALT);

`ifdef PC_GEN_MISALIGN_TRAP_EN
  assign w_trap_bad  = |(trap_pc & MASK);
  assign w_redir_bad = |(redirect_pc & MASK);
  assign w_trap_tgt  = trap_pc;
  assign w_redir_tgt = redirect_pc;
`else
  assign w_trap_bad  = 1'b0;
  assign w_redir_bad = 1'b0;
  assign w_trap_tgt  = trap_pc & ~MASK;
  assign w_redir_tgt = redirect_pc & ~MASK;
`endif

  // A trap in the same cycle always discards the redirect, even when the
  // trap itself is dropped for misalignment.
  assign w_take_trap  = trap_valid & w_active & ~w_trap_bad;
  assign w_take_redir = redirect_valid & ~trap_valid & (r_state == S_RUN) & ~w_redir_bad;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_BOOT;
      r_pc     <= RESET_VECTOR;
      r_valid  <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_BOOT: begin
          r_state <= S_RUN;
          r_pc    <= RESET_VECTOR;
          r_valid <= 1'b1;
        end
        S_RUN, S_HALT: begin
          if (w_take_trap) begin
            r_state  <= S_RUN;
            r_pc     <= w_trap_tgt;
            r_valid  <= 1'b1;
            r_halted <= 1'b0;
          end else if (w_take_redir) begin
            r_pc    <= w_redir_tgt;
            r_valid <= 1'b1;
          end else if (r_state == S_RUN) begin
            if (w_hs) r_pc <= r_pc + INC;
            // Park only once the outstanding request has been accepted.
            if (halt_req && (w_hs || !r_valid)) begin
              r_state  <= S_HALT;
              r_valid  <= 1'b0;
              r_halted <= 1'b1;
            end
          end else if (!halt_req) begin
            r_state  <= S_RUN;
            r_valid  <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_BOOT;
          r_pc     <= RESET_VECTOR;
          r_valid  <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef PC_GEN_MISALIGN_TRAP_EN
  logic r_misalign;
  always_ff @(posedge clk) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= w_active & ((trap_valid & w_trap_bad) |
                              (redirect_valid & ~trap_valid & (r_state == S_RUN) & w_redir_bad));
  end
  assign misalign_err = r_misalign;
`else
  assign misalign_err = 1'b0;
`endif

  assign fetch_valid = r_valid;
  assign fetch_pc    = r_pc;
  assign halted      = r_halted;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen (XLEN=32, RESET_VECTOR=0, ALIGN_BITS=2).
// Directed scenarios first, then randomized traffic compared every cycle
// against a cycle-level reference model of the fetch PC rules.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_pc;
  logic        halt_req;
  logic        halted;
  logic        misalign_err;

  int n_cmp = 0;
  int n_err = 0;

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .ALIGN_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .trap_valid(trap_valid), .trap_pc(trap_pc),
    .halt_req(halt_req), .halted(halted), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Reference model: where is the fetch stream, is it parked, is it booting.
  bit          m_boot;
  bit          m_park;
  logic [31:0] m_pc;
  logic        m_v;
  logic        m_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit misaligned(input logic [31:0] a);
`ifdef PC_GEN_MISALIGN_TRAP_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] tgt(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  task automatic model_step();
    bit hs;
    bit done;
    m_e = 1'b0;
    if (!rst_n) begin
      m_boot = 1; m_park = 0; m_pc = 32'h0; m_v = 1'b0;
      return;
    end
    if (m_boot) begin
      m_boot = 0; m_v = 1'b1; m_pc = 32'h0;
      return;
    end
    hs   = m_v && fetch_ready;
    done = 0;
    if (trap_valid) begin
      if (misaligned(trap_pc)) m_e = 1'b1;
      else begin m_pc = tgt(trap_pc); m_v = 1'b1; m_park = 0; done = 1; end
    end else if (redirect_valid && !m_park) begin
      if (misaligned(redirect_pc)) m_e = 1'b1;
      else begin m_pc = tgt(redirect_pc); m_v = 1'b1; done = 1; end
    end
    if (!done) begin
      if (m_park) begin
        if (!halt_req) begin m_park = 0; m_v = 1'b1; end
      end else begin
        if (hs) m_pc = m_pc + 32'd4;
        if (halt_req && hs) begin m_park = 1; m_v = 1'b0; end
      end
    end
  endtask

  // Inputs are applied at the falling edge; the check follows the next rise.
  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("valid",  {31'b0, fetch_valid},  {31'b0, m_v});
    chk("pc",     fetch_pc,              m_pc);
    chk("halted", {31'b0, halted},       {31'b0, m_park});
    chk("merr",   {31'b0, misalign_err}, {31'b0, m_e});
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0; trap_valid = 1'b0;
    redirect_pc = 32'h0; trap_pc = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0; fetch_ready = 1'b1; halt_req = 1'b0;
    idle_inputs();
    m_boot = 1; m_park = 0; m_pc = 0; m_v = 0; m_e = 0;
    @(negedge clk);

    // Reset two cycles, then boot and sequential fetch.
    cyc(); cyc();
    chk("rst_valid", {31'b0, fetch_valid}, 32'h0);
    chk("rst_pc", fetch_pc, 32'h0);
    rst_n = 1'b1;
    cyc(); chk("boot_pc", fetch_pc, 32'h0); chk("boot_v", {31'b0, fetch_valid}, 32'h1);
    cyc(); chk("seq4", fetch_pc, 32'h4);
    cyc(); chk("seq8", fetch_pc, 32'h8);
    cyc(); chk("seqC", fetch_pc, 32'hC);
    cyc(); chk("seq10", fetch_pc, 32'h10);

    // Back-pressure.
    fetch_ready = 1'b0;
    repeat (3) cyc();
    chk("stall_pc", fetch_pc, 32'h10);
    chk("stall_v", {31'b0, fetch_valid}, 32'h1);
    fetch_ready = 1'b1;
    cyc(); chk("unstall", fetch_pc, 32'h14);

    // Trap beats redirect.
    trap_valid = 1'b1; trap_pc = 32'h100;
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    cyc(); chk("trap_prio", fetch_pc, 32'h100);
    idle_inputs();

    // Halt and resume at 0x20.
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    cyc(); chk("redir20", fetch_pc, 32'h20);
    idle_inputs(); halt_req = 1'b1;
    cyc(); chk("halted", {31'b0, halted}, 32'h1); chk("halt_v", {31'b0, fetch_valid}, 32'h0);
    cyc(); chk("halt_pc", fetch_pc, 32'h24);
    halt_req = 1'b0;
    cyc(); chk("resume_pc", fetch_pc, 32'h24); chk("resume_v", {31'b0, fetch_valid}, 32'h1);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_pc = 32'h202;
    cyc();
`ifdef PC_GEN_MISALIGN_TRAP_EN
    chk("mis_pc", fetch_pc, 32'h28);
    chk("mis_err", {31'b0, misalign_err}, 32'h1);
`else
    chk("mis_pc", fetch_pc, 32'h200);
    chk("mis_err", {31'b0, misalign_err}, 32'h0);
`endif
    idle_inputs();

    // Wrap at the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cyc(); idle_inputs();
    cyc(); chk("wrap", fetch_pc, 32'h0);

    // Reset while stalled.
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    cyc(); idle_inputs(); fetch_ready = 1'b0;
    cyc(); rst_n = 1'b0;
    cyc(); chk("rst_stall_pc", fetch_pc, 32'h0); chk("rst_stall_v", {31'b0, fetch_valid}, 32'h0);
    rst_n = 1'b1; fetch_ready = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n          = ($urandom_range(63) != 0);
      fetch_ready    = ($urandom_range(3) != 0);
      trap_valid     = ($urandom_range(15) == 0);
      redirect_valid = ($urandom_range(7) == 0);
      trap_pc        = $urandom;
      redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
      if ($urandom_range(9) == 0) halt_req = ~halt_req;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
